sclic_irq_arbiter: RTL and testbench
====================================

Name: sclic_irq_arbiter

Overview:
- Parametrised CLIC interrupt arbiter between the CLIC source inputs and the CVA6 CSR/controller interrupt interface.
- Latches edge-triggered pending bits and filters sources by enable and the mintthresh threshold.
- Selects the highest-level eligible source and offers it to the core with a valid/ready handshake.
- Revokes a pending offer through a kill request/acknowledge pair when a strictly higher-level source arrives, or when the offered source stops being eligible.

Parameters:
- NumSrc, 256: number of interrupt sources (≥2).
- CtlWidth, 8: width of per-source clicintctl level/priority field.
- IdWidth, $clog2(NumSrc): width of interrupt ID.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- intr_src_i  in  NumSrc  raw interrupt lines.
- intr_ie_i  in  NumSrc  per-source enable.
- intr_trig_i  in  NumSrc  1 = rising-edge triggered, 0 = level triggered.
- intr_ctl_i  in  NumSrc*CtlWidth  per-source level; source i occupies bits [i*CtlWidth +: CtlWidth].
- mintthresh_i  in  CtlWidth  interrupt threshold.
- irq_valid_o  out  1  interrupt offered.
- irq_ready_i  in  1  core accepts the offer.
- irq_id_o  out  IdWidth  offered source ID.
- irq_level_o  out  CtlWidth  offered level.
- irq_kill_req_o  out  1  request to retract the offer.
- irq_kill_ack_i  in  1  core acknowledges the retraction.

Behaviour:
- Reset (async, rst_i=1): every register cleared, including pending, src_q, candidate and FSM (state IDLE). All outputs are 0 while in reset and immediately after it.
- Edge pending, source with intr_trig_i=1:
  - pend[i] sets at the clock edge where intr_src_i[i]=1 and src_q[i]=0.
  - pend[i] clears on an accepted handshake (valid & ready) with irq_id_o==i.
  - If set and clear happen in the same cycle, set wins.
- Level pending, source with intr_trig_i=0: pend[i] <= intr_src_i[i] every cycle. A handshake does not clear it.
- Eligibility: elig[i] = pend[i] & intr_ie_i[i] & (ctl[i] > mintthresh_i), unsigned strict compare.
- Arbitration: combinational over elig.
  - Winner is the maximum ctl; ties go to the lowest ID.
  - The result is registered into cand_valid/cand_id/cand_level every cycle.
- Latency: an input edge at clock t sets pend at t+1, cand at t+2, and irq_valid_o after edge t+3 (IDLE→OFFER). Three cycles from source to valid.
- FSM:
  - IDLE: valid=0, kill=0. If cand_valid, load out_id/out_level from cand and go to OFFER.
  - OFFER: valid=1. irq_id_o and irq_level_o are stable for the whole of OFFER. Transitions, in priority order:
    1. irq_ready_i=1: handshake completes; go to IDLE. This forces a one-cycle valid=0 bubble.
    2. cand_valid & cand_level > out_level: go to KILL.
    3. elig[out_id]=0 (level line dropped, ie cleared, ctl or threshold changed): go to KILL.
    4. Otherwise stay in OFFER.
  - KILL: valid=0, irq_kill_req_o=1, held until irq_kill_ack_i=1, then go to IDLE. The edge pending bit of the retracted source is NOT cleared. A ready received in KILL is ignored.
- A kill_ack received outside KILL is ignored.
- A ready received outside OFFER is ignored.
- Simultaneous ready and higher-priority arrival: the handshake completes. The new winner is offered after the IDLE bubble.
- Equal-level newcomer while in OFFER: no kill.
- Reset asserted mid-handshake or mid-kill: immediate return to IDLE with outputs low. The core is responsible for discarding in-flight state.
- Arithmetic: all compares unsigned on CtlWidth. ID is the binary index, zero-extended.

Test Plan:
- Level src 5, ctl=0x40, thresh=0x10, ie=1; ready held 0 → valid rises 3 cycles after assertion with id=5, level=0x40. ready=1 for one cycle → valid low for ≥1 cycle, then re-offered (source still pending).
- Edge src 7 pulsed one cycle, ctl=0x20 → offered id=7. After handshake, pend[7]=0 and valid stays 0. A second pulse arriving in the same cycle as the handshake leaves pend[7]=1 and id=7 is re-offered.
- While offering id=5 (level 0x40), assert src 200 with ctl=0x80 → irq_kill_req_o=1 with valid=0. Ack after 2 cycles → IDLE, then offer id=200, level=0x80.
- Srcs 3 and 9 both at ctl=0x30 → id=3 offered. Src 9 raised to 0x30 while offering 3 → no kill.
- Offer id=5, then drop intr_ie_i[5] → KILL. Ack → valid stays 0 (no eligible source). Same test with ctl=thresh=0x40 → never offered.
- Ready and a higher-priority arrival in the same cycle → handshake counted, no kill, higher source offered after the bubble. Assert rst_i during KILL → all outputs 0 asynchronously.

Source files
------------

// File: rtl/sclic_irq_arbiter.sv
// -----------------------------------------------------------------------------
// sclic_irq_arbiter
//
// CLIC interrupt arbiter. It sits between the CLIC source lines and the core's
// CSR/controller interrupt interface. It latches pending state, filters sources
// by enable and threshold, and picks the highest-level eligible source. The
// winner is offered to the core over a valid/ready handshake. An offer is
// retracted through a kill request/acknowledge pair when a strictly
// higher-level source appears, or when the offered source stops being eligible.
//
// Ports:
//   clk_i           clock
//   rst_i           asynchronous active-high reset
//   intr_src_i      raw interrupt lines, one per source
//   intr_ie_i       per-source enable
//   intr_trig_i     1 = rising-edge triggered, 0 = level triggered
//   intr_ctl_i      per-source level; source i at [i*CtlWidth +: CtlWidth]
//   mintthresh_i    threshold; a source is eligible only if level > threshold
//   irq_valid_o     an interrupt is being offered
//   irq_ready_i     core accepts the offer
//   irq_id_o        offered source ID
//   irq_level_o     offered level
//   irq_kill_req_o  request to retract the current offer
//   irq_kill_ack_i  core acknowledges the retraction
// -----------------------------------------------------------------------------
module sclic_irq_arbiter #(
    parameter int NumSrc   = 256,
    parameter int CtlWidth = 8,
    parameter int IdWidth  = $clog2(NumSrc)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumSrc-1:0]            intr_src_i,
    input  logic [NumSrc-1:0]            intr_ie_i,
    input  logic [NumSrc-1:0]            intr_trig_i,
    input  logic [NumSrc*CtlWidth-1:0]   intr_ctl_i,
    input  logic [CtlWidth-1:0]          mintthresh_i,
    output logic                         irq_valid_o,
    input  logic                         irq_ready_i,
    output logic [IdWidth-1:0]           irq_id_o,
    output logic [CtlWidth-1:0]          irq_level_o,
    output logic                         irq_kill_req_o,
    input  logic                         irq_kill_ack_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        KILL  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [NumSrc-1:0]     src_q;
    logic [NumSrc-1:0]     pend;
    logic [NumSrc-1:0]     elig;
    logic [NumSrc-1:0]     arb_mask;
    logic                  accept;
    logic                  out_edge_set;

    logic                  win_valid;
    logic [IdWidth-1:0]    win_id;
    logic [CtlWidth-1:0]   win_level;

    logic                  cand_valid;
    logic [IdWidth-1:0]    cand_id;
    logic [CtlWidth-1:0]   cand_level;

    logic [IdWidth-1:0]    out_id;
    logic [CtlWidth-1:0]   out_level;

    assign accept       = (state_q == OFFER) && irq_ready_i;
    assign out_edge_set = intr_src_i[out_id] && !src_q[out_id];

    always_comb begin
        elig = '0;
        for (int i = 0; i < NumSrc; i++) begin
            elig[i] = pend[i] && intr_ie_i[i] &&
                      (intr_ctl_i[i*CtlWidth +: CtlWidth] > mintthresh_i);
        end
    end

    // An edge source accepted this cycle loses its pending bit at this edge
    // (unless a new edge re-arms it). It is dropped from arbitration now, so
    // that the candidate captured here does not re-offer a consumed interrupt.
    always_comb begin
        arb_mask = elig;
        if (accept && intr_trig_i[out_id] && !out_edge_set) begin
            arb_mask[out_id] = 1'b0;
        end
    end

    // Highest level wins. The strict '>' keeps the first (lowest) ID on ties.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        win_level = '0;
        for (int i = 0; i < NumSrc; i++) begin
            if (arb_mask[i] &&
                (!win_valid || (intr_ctl_i[i*CtlWidth +: CtlWidth] > win_level))) begin
                win_valid = 1'b1;
                win_id    = IdWidth'(i);
                win_level = intr_ctl_i[i*CtlWidth +: CtlWidth];
            end
        end
    end

    // Pending latch: edge sources set on a rising edge and clear on their own
    // handshake (set wins). Level sources simply follow the line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_q <= '0;
            pend  <= '0;
        end else begin
            src_q <= intr_src_i;
            for (int i = 0; i < NumSrc; i++) begin
                if (intr_trig_i[i]) begin
                    if (intr_src_i[i] && !src_q[i]) begin
                        pend[i] <= 1'b1;
                    end else if (accept && (out_id == IdWidth'(i))) begin
                        pend[i] <= 1'b0;
                    end
                end else begin
                    pend[i] <= intr_src_i[i];
                end
            end
        end
    end

    // Candidate register: arbitration result, refreshed every cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cand_valid <= 1'b0;
            cand_id    <= '0;
            cand_level <= '0;
        end else begin
            cand_valid <= win_valid;
            cand_id    <= win_id;
            cand_level <= win_level;
        end
    end

    // Offer FSM: state register and the offered ID/level, which only change
    // when leaving IDLE so they stay stable for the whole offer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            out_id    <= '0;
            out_level <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && cand_valid) begin
                out_id    <= cand_id;
                out_level <= cand_level;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        irq_valid_o    = 1'b0;
        irq_kill_req_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (cand_valid) begin
                    state_d = OFFER;
                end
            end
            OFFER: begin
                irq_valid_o = 1'b1;
                // A completed handshake takes precedence over any retraction.
                if (irq_ready_i) begin
                    state_d = IDLE;
                end else if (cand_valid && (cand_level > out_level)) begin
                    state_d = KILL;
                end else if (!elig[out_id]) begin
                    state_d = KILL;
                end
            end
            KILL: begin
                irq_kill_req_o = 1'b1;
                if (irq_kill_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign irq_id_o    = out_id;
    assign irq_level_o = out_level;

endmodule

// File: tb/tb_sclic_irq_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sclic_irq_arbiter
//
// Self-checking bench for sclic_irq_arbiter: a table of static arbitration
// vectors, hand-written multi-cycle sequences, and a randomized run compared
// cycle by cycle against a behavioural model of the interrupt offer protocol.
// -----------------------------------------------------------------------------
module tb_sclic_irq_arbiter;

    localparam int NumSrc   = 256;
    localparam int CtlWidth = 8;
    localparam int IdWidth  = 8;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [NumSrc-1:0]           src;
    logic [NumSrc-1:0]           ie;
    logic [NumSrc-1:0]           trig;
    logic [NumSrc*CtlWidth-1:0]  ctl;
    logic [CtlWidth-1:0]         thresh;
    logic                        ready;
    logic                        ack;
    logic                        valid;
    logic                        kill;
    logic [IdWidth-1:0]          id;
    logic [CtlWidth-1:0]         level;

    int checks = 0;
    int errors = 0;

    sclic_irq_arbiter #(
        .NumSrc  (NumSrc),
        .CtlWidth(CtlWidth),
        .IdWidth (IdWidth)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .intr_src_i    (src),
        .intr_ie_i     (ie),
        .intr_trig_i   (trig),
        .intr_ctl_i    (ctl),
        .mintthresh_i  (thresh),
        .irq_valid_o   (valid),
        .irq_ready_i   (ready),
        .irq_id_o      (id),
        .irq_level_o   (level),
        .irq_kill_req_o(kill),
        .irq_kill_ack_i(ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         a_id; int a_lvl; bit a_en;
        int         b_id; int b_lvl; bit b_en;
        int         c_id; int c_lvl; bit c_en;
        logic [7:0] th;
        bit         ev;
        int         eid;
        int         elvl;
    } vec_t;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_out(input string name, input bit ev, input bit ek,
                             input int eid, input int elvl);
        chk({name, "_valid"}, 32'(valid), 32'(ev));
        chk({name, "_kill"},  32'(kill),  32'(ek));
        if (ev) begin
            chk({name, "_id"},    32'(id),    32'(eid));
            chk({name, "_level"}, 32'(level), 32'(elvl));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        src = '0; ie = '0; trig = '0; ctl = '0; thresh = '0;
        ready = 1'b0; ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_src(input int i, input int lvl, input bit en, input bit tr, input bit line);
        ctl[i*CtlWidth +: CtlWidth] = lvl[7:0];
        ie[i]   = en;
        trig[i] = tr;
        src[i]  = line;
    endtask

    // ---------------- behavioural model ----------------
    bit m_pend [NumSrc];
    bit m_srcq [NumSrc];
    bit m_cv;
    int m_cid, m_clvl;
    bit m_offer, m_kill;
    int m_oid, m_olvl;

    function automatic int lvl_of(input int i);
        return int'(ctl[i*CtlWidth +: CtlWidth]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NumSrc; i++) begin
            m_pend[i] = 1'b0;
            m_srcq[i] = 1'b0;
        end
        m_cv = 1'b0; m_cid = 0; m_clvl = 0;
        m_offer = 1'b0; m_kill = 1'b0; m_oid = 0; m_olvl = 0;
    endtask

    // One clock edge of the model, evaluated from the pre-edge inputs.
    task automatic model_step();
        bit el [NumSrc];
        int best_id, best_lvl, old_oid;
        bit acc;
        acc      = m_offer && ready;
        old_oid  = m_oid;
        best_id  = -1;
        best_lvl = -1;
        for (int i = 0; i < NumSrc; i++) begin
            el[i] = m_pend[i] && ie[i] && (lvl_of(i) > int'(thresh));
        end
        // Scan downward with >= so the lowest ID wins a tie.
        for (int i = NumSrc - 1; i >= 0; i--) begin
            if (acc && i == old_oid && trig[i] && !(src[i] && !m_srcq[i])) continue;
            if (el[i] && lvl_of(i) >= best_lvl) begin
                best_id  = i;
                best_lvl = lvl_of(i);
            end
        end
        if (m_offer) begin
            if (ready) begin
                m_offer = 1'b0;
            end else if ((m_cv && m_clvl > m_olvl) || !el[m_oid]) begin
                m_offer = 1'b0;
                m_kill  = 1'b1;
            end
        end else if (m_kill) begin
            if (ack) m_kill = 1'b0;
        end else if (m_cv) begin
            m_offer = 1'b1;
            m_oid   = m_cid;
            m_olvl  = m_clvl;
        end
        m_cv = (best_id >= 0);
        if (m_cv) begin
            m_cid  = best_id;
            m_clvl = best_lvl;
        end
        for (int i = 0; i < NumSrc; i++) begin
            if (trig[i]) begin
                if (src[i] && !m_srcq[i]) m_pend[i] = 1'b1;
                else if (acc && i == old_oid) m_pend[i] = 1'b0;
            end else begin
                m_pend[i] = src[i];
            end
            m_srcq[i] = src[i];
        end
    endtask

    // ---------------- test ----------------
    vec_t vecs [8];
    int   pool [8];
    int   lvls [5];

    initial begin
        rst = 1'b1;
        clear_inputs();

        vecs[0] = '{a_id:5,   a_lvl:'h40, a_en:1, b_id:9,   b_lvl:'h20, b_en:1, c_id:200, c_lvl:'h10, c_en:1, th:8'h10, ev:1, eid:5,   elvl:'h40};
        vecs[1] = '{a_id:3,   a_lvl:'h30, a_en:1, b_id:9,   b_lvl:'h30, b_en:1, c_id:1,   c_lvl:'h20, c_en:1, th:8'h10, ev:1, eid:3,   elvl:'h30};
        vecs[2] = '{a_id:5,   a_lvl:'h40, a_en:1, b_id:6,   b_lvl:'h40, b_en:1, c_id:7,   c_lvl:'h30, c_en:1, th:8'h40, ev:0, eid:0,   elvl:0};
        vecs[3] = '{a_id:10,  a_lvl:'h80, a_en:0, b_id:20,  b_lvl:'h70, b_en:1, c_id:255, c_lvl:'h70, c_en:1, th:8'h00, ev:1, eid:20,  elvl:'h70};
        vecs[4] = '{a_id:255, a_lvl:'hFF, a_en:1, b_id:0,   b_lvl:'hFF, b_en:1, c_id:128, c_lvl:'h01, c_en:1, th:8'h00, ev:1, eid:0,   elvl:'hFF};
        vecs[5] = '{a_id:255, a_lvl:'h01, a_en:1, b_id:254, b_lvl:'h00, b_en:1, c_id:100, c_lvl:'h00, c_en:0, th:8'h00, ev:1, eid:255, elvl:'h01};
        vecs[6] = '{a_id:4,   a_lvl:'h90, a_en:0, b_id:8,   b_lvl:'h90, b_en:0, c_id:12,  c_lvl:'h90, c_en:0, th:8'h00, ev:0, eid:0,   elvl:0};
        vecs[7] = '{a_id:0,   a_lvl:'h01, a_en:1, b_id:1,   b_lvl:'h01, b_en:1, c_id:2,   c_lvl:'h02, c_en:1, th:8'h01, ev:1, eid:2,   elvl:'h02};

        @(negedge clk);
        do_reset();
        check_out("reset", 0, 0, 0, 0);
        chk("reset_id", 32'(id), 0);
        chk("reset_level", 32'(level), 0);

        // Table of static arbitration cases with level sources held high.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            set_src(vecs[v].a_id, vecs[v].a_lvl, vecs[v].a_en, 1'b0, 1'b1);
            set_src(vecs[v].b_id, vecs[v].b_lvl, vecs[v].b_en, 1'b0, 1'b1);
            set_src(vecs[v].c_id, vecs[v].c_lvl, vecs[v].c_en, 1'b0, 1'b1);
            thresh = vecs[v].th;
            for (int k = 0; k < 4; k++) tick();
            check_out($sformatf("vec%0d", v), vecs[v].ev, 0, vecs[v].eid, vecs[v].elvl);
        end

        // Level source 5: three-cycle latency, bubble after handshake, re-offer.
        do_reset();
        thresh = 8'h10;
        set_src(5, 'h40, 1, 0, 1);
        tick(); tick();
        check_out("lat_c2", 0, 0, 0, 0);
        tick();
        check_out("lat_c3", 1, 0, 5, 'h40);
        ready = 1'b1; tick(); ready = 1'b0;
        check_out("lvl_bubble", 0, 0, 0, 0);
        tick();
        check_out("lvl_reoffer", 1, 0, 5, 'h40);

        // Edge source 7: consumed by the handshake, re-armed by a coincident pulse.
        do_reset();
        thresh = 8'h10;
        set_src(7, 'h20, 1, 1, 1);
        tick(); src[7] = 1'b0;
        tick(); tick();
        check_out("edge_offer", 1, 0, 7, 'h20);
        ready = 1'b1; tick(); ready = 1'b0;
        check_out("edge_hs", 0, 0, 0, 0);
        tick(); tick(); tick();
        check_out("edge_cleared", 0, 0, 0, 0);
        src[7] = 1'b1; tick(); src[7] = 1'b0;
        tick(); tick();
        check_out("edge_offer2", 1, 0, 7, 'h20);
        ready = 1'b1; src[7] = 1'b1; tick(); ready = 1'b0; src[7] = 1'b0;
        check_out("edge_setwins_bubble", 0, 0, 0, 0);
        tick();
        check_out("edge_setwins_reoffer", 1, 0, 7, 'h20);

        // Higher-level newcomer forces a kill; ack, then offer the newcomer.
        do_reset();
        thresh = 8'h10;
        set_src(5, 'h40, 1, 0, 1);
        tick(); tick(); tick();
        check_out("kill_pre", 1, 0, 5, 'h40);
        set_src(200, 'h80, 1, 0, 1);
        tick(); tick();
        check_out("kill_still_offer", 1, 0, 5, 'h40);
        tick();
        check_out("kill_req", 0, 1, 0, 0);
        ready = 1'b1; tick(); ready = 1'b0;
        check_out("kill_ready_ignored", 0, 1, 0, 0);
        ack = 1'b1; tick(); ack = 1'b0;
        check_out("kill_acked", 0, 0, 0, 0);
        tick();
        check_out("kill_new_offer", 1, 0, 200, 'h80);
        ack = 1'b1; tick(); ack = 1'b0;
        check_out("ack_outside_kill", 1, 0, 200, 'h80);

        // Equal-level newcomer does not kill.
        do_reset();
        thresh = 8'h10;
        set_src(3, 'h30, 1, 0, 1);
        set_src(9, 'h20, 1, 0, 1);
        tick(); tick(); tick();
        check_out("tie_offer", 1, 0, 3, 'h30);
        ctl[9*CtlWidth +: CtlWidth] = 8'h30;
        tick(); tick(); tick();
        check_out("tie_nokill", 1, 0, 3, 'h30);

        // Offered source loses its enable: kill, then nothing left to offer.
        do_reset();
        thresh = 8'h10;
        set_src(5, 'h40, 1, 0, 1);
        tick(); tick(); tick();
        check_out("ie_offer", 1, 0, 5, 'h40);
        ie[5] = 1'b0; tick();
        check_out("ie_kill", 0, 1, 0, 0);
        ack = 1'b1; tick(); ack = 1'b0;
        check_out("ie_acked", 0, 0, 0, 0);
        tick(); tick();
        check_out("ie_quiet", 0, 0, 0, 0);

        // Ready and a higher arrival together: the handshake wins.
        do_reset();
        thresh = 8'h10;
        set_src(5, 'h40, 1, 0, 1);
        tick(); tick(); tick();
        set_src(200, 'h80, 1, 0, 1);
        tick(); tick();
        ready = 1'b1; tick(); ready = 1'b0;
        check_out("race_bubble", 0, 0, 0, 0);
        tick();
        check_out("race_offer", 1, 0, 200, 'h80);

        // Asynchronous reset in the middle of a kill.
        ie[200] = 1'b0; tick();
        check_out("rstkill_pre", 0, 1, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("rstkill_valid", 32'(valid), 0);
        chk("rstkill_kill",  32'(kill),  0);
        chk("rstkill_id",    32'(id),    0);
        chk("rstkill_level", 32'(level), 0);
        @(negedge clk);

        // Randomized run against the behavioural model.
        pool = '{0, 3, 5, 7, 9, 100, 200, 255};
        lvls = '{'h08, 'h10, 'h20, 'h40, 'h80};
        do_reset();
        model_reset();
        thresh = 8'h10;
        for (int p = 0; p < 8; p++) begin
            set_src(pool[p], lvls[$urandom_range(0, 4)], 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int p = 0; p < 8; p++) begin
                if ($urandom_range(0, 5) == 0) src[pool[p]] = ~src[pool[p]];
                if ($urandom_range(0, 39) == 0)
                    ctl[pool[p]*CtlWidth +: CtlWidth] = 8'(lvls[$urandom_range(0, 4)]);
                if ($urandom_range(0, 49) == 0) ie[pool[p]] = ~ie[pool[p]];
            end
            if ($urandom_range(0, 59) == 0) thresh = 8'($urandom_range(0, 2) * 'h10);
            ready = ($urandom_range(0, 3) == 0);
            ack   = ($urandom_range(0, 2) == 0);
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk("rnd_valid", 32'(valid), 32'(m_offer));
            chk("rnd_kill",  32'(kill),  32'(m_kill));
            if (m_offer) begin
                chk("rnd_id",    32'(id),    32'(m_oid));
                chk("rnd_level", 32'(level), 32'(m_olvl));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
